// File: rtl/frog_river_ride.sv
// Frog river-ride controller: lands the frog on logs, carries it with lane speed, drowns it off-log or past the banks.
// Outputs are registered one cycle after the evaluated inputs; optional landing grace window built with FROG_GRACE_EN.
module frog_river_ride #(
  parameter int X_OFFSET_LEFT  = 96,
  parameter int X_OFFSET_RIGHT = 544,
  parameter int FROG_SIZE      = 32,
  parameter int GRACE_CYCLES   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [9:0]   frog_x,
  input  logic [2:0]   frog_lane,
  input  logic         frog_in_river,
  input  logic         frog_hop,
  input  logic         respawn,
  input  logic [129:0] log_x_flat,
  input  logic [59:0]  log_speed_flat,
  input  logic [59:0]  log_len_flat,
  output logic         on_log,
  output logic         carry_valid,
  output logic [9:0]   carry_dx,
  output logic         drown,
  output logic [1:0]   ride_idx
);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, RIDING, DEAD} state_t;

  localparam logic [10:0]        HALF    = 11'(FROG_SIZE / 2);
  localparam logic signed [11:0] EDGE_LO = 12'(X_OFFSET_LEFT);
  localparam logic signed [11:0] EDGE_HI = 12'(X_OFFSET_RIGHT - FROG_SIZE);

  state_t state, state_nxt;

  // Padded tables: invalid lanes read zero length/speed and can never match.
  logic [9:0] log_x [16];
  logic [9:0] len_a [8];
  logic [9:0] spd_a [8];

  logic              lane_ok;
  logic [10:0]       centre;
  logic [9:0]        lane_len;
  logic [9:0]        lane_spd;
  logic [3:0]        base;
  logic              sup;
  logic [1:0]        sup_idx;
  logic signed [11:0] pos;
  logic              edge_bad;
  logic              grace_out;

  logic       on_log_d, carry_valid_d, drown_d;
  logic [9:0] carry_dx_d;
  logic [1:0] ride_idx_d;

  function automatic logic hits(input logic [9:0] lx, input logic [9:0] len, input logic [10:0] c);
    return ({1'b0, lx} <= c) && (c < ({1'b0, lx} + {1'b0, len}));
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) log_x[i] = (i < 13) ? log_x_flat[i*10 +: 10] : 10'd0;
    for (int i = 0; i < 8; i++) begin
      len_a[i] = (i < 6) ? log_len_flat[i*10 +: 10]   : 10'd0;
      spd_a[i] = (i < 6) ? log_speed_flat[i*10 +: 10] : 10'd0;
    end
  end

  always_comb begin
    lane_ok  = (frog_lane <= 3'd5);
    centre   = {1'b0, frog_x} + HALF;
    lane_len = len_a[frog_lane];
    lane_spd = spd_a[frog_lane];
    base     = (frog_lane == 3'd0) ? 4'd0 : {frog_lane, 1'b1};
    sup      = 1'b0;
    sup_idx  = 2'd0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int j = 2; j >= 0; j--) begin
      if (lane_ok && (frog_lane == 3'd0 || j < 2) && hits(log_x[base + 4'(j)], lane_len, centre)) begin
        sup     = 1'b1;
        sup_idx = 2'(j);
      end
    end
    pos      = $signed({2'b00, frog_x}) + $signed({{2{lane_spd[9]}}, lane_spd});
    edge_bad = (lane_spd != 10'd0) && ((pos < EDGE_LO) || (pos > EDGE_HI));
  end

`ifdef FROG_GRACE_EN
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_CYCLES - 1);
  logic [7:0] grace_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)                                    grace_cnt <= 8'd0;
    else if (state == CHECK && state_nxt == CHECK)   grace_cnt <= grace_cnt + 8'd1;
    else                                             grace_cnt <= 8'd0;
  end

  assign grace_out = (grace_cnt >= GRACE_LAST);
`else
  assign grace_out = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      on_log      <= 1'b0;
      carry_valid <= 1'b0;
      carry_dx    <= 10'd0;
      drown       <= 1'b0;
      ride_idx    <= 2'd0;
    end else begin
      state       <= state_nxt;
      on_log      <= on_log_d;
      carry_valid <= carry_valid_d;
      carry_dx    <= carry_dx_d;
      drown       <= drown_d;
      ride_idx    <= ride_idx_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (frog_in_river) state_nxt = SETTLE;
      SETTLE: begin
        if (!frog_in_river) state_nxt = IDLE;
        else if (!frog_hop) state_nxt = CHECK;
      end
      CHECK: begin
        if (!frog_in_river)  state_nxt = IDLE;
        else if (frog_hop)   state_nxt = SETTLE;
        else if (sup)        state_nxt = RIDING;
        else if (grace_out)  state_nxt = DEAD;
      end
      RIDING: begin
        if (!frog_in_river)        state_nxt = IDLE;
        else if (frog_hop)         state_nxt = SETTLE;
        else if (!sup || edge_bad) state_nxt = DEAD;
      end
      DEAD:   if (respawn) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    on_log_d      = (state_nxt == RIDING);
    ride_idx_d    = on_log_d ? sup_idx : 2'd0;
    drown_d       = (state != DEAD) && (state_nxt == DEAD);
    carry_valid_d = (state == RIDING) && (state_nxt == RIDING) && (lane_spd != 10'd0);
    carry_dx_d    = carry_valid_d ? lane_spd : 10'd0;
  end

endmodule

// File: tb/tb_frog_river_ride.sv
// Scoreboarded bench for frog_river_ride: driver queues expected outputs per cycle, monitor checks on the falling edge.
module tb_frog_river_ride;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   frog_x;
  logic [2:0]   frog_lane;
  logic         frog_in_river;
  logic         frog_hop;
  logic         respawn;
  logic [129:0] log_x_flat;
  logic [59:0]  log_speed_flat;
  logic [59:0]  log_len_flat;
  logic         on_log;
  logic         carry_valid;
  logic [9:0]   carry_dx;
  logic         drown;
  logic [1:0]   ride_idx;

  typedef struct packed {
    logic       on;
    logic       cv;
    logic [9:0] dx;
    logic       dr;
    logic [1:0] idx;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  frog_river_ride dut (
    .clk(clk), .reset_n(reset_n), .frog_x(frog_x), .frog_lane(frog_lane),
    .frog_in_river(frog_in_river), .frog_hop(frog_hop), .respawn(respawn),
    .log_x_flat(log_x_flat), .log_speed_flat(log_speed_flat), .log_len_flat(log_len_flat),
    .on_log(on_log), .carry_valid(carry_valid), .carry_dx(carry_dx), .drown(drown),
    .ride_idx(ride_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = '{on_log, carry_valid, carry_dx, drown, ride_idx};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s got on=%b cv=%b dx=%h dr=%b idx=%0d want on=%b cv=%b dx=%h dr=%b idx=%0d",
                 n, g.on, g.cv, g.dx, g.dr, g.idx, e.on, e.cv, e.dx, e.dr, e.idx);
      end
    end
  end

  task automatic cyc(input logic on, input logic cv, input logic [9:0] dx,
                     input logic dr, input logic [1:0] idx, input string nm);
    @(posedge clk);
    exp_q.push_back('{on, cv, dx, dr, idx});
    name_q.push_back(nm);
    #1;
  endtask

  task automatic idle0(input string nm);
    cyc(1'b0, 1'b0, 10'd0, 1'b0, 2'd0, nm);
  endtask

  task automatic set_log(input int i, input logic [9:0] x);
    log_x_flat[i*10 +: 10] = x;
  endtask

  task automatic set_speed(input int lane, input logic [9:0] v);
    log_speed_flat[lane*10 +: 10] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; frog_x = 10'd0; frog_lane = 3'd0; frog_in_river = 1'b0;
    frog_hop = 1'b0; respawn = 1'b0; log_speed_flat = '0;
    for (int i = 0; i < 13; i++) set_log(i, 10'd900);
    for (int l = 0; l < 6; l++) log_len_flat[l*10 +: 10] = 10'd96;

    idle0("reset");
    reset_n = 1'b1;

    // Landing in lane 1 on log0 at 180, centre 216
    frog_lane = 3'd1; frog_x = 10'd200; set_log(3, 10'd180); set_log(4, 10'd600);
    frog_in_river = 1'b1; frog_hop = 1'b1;
    idle0("idle_to_settle");
    idle0("settle_hold");
    frog_hop = 1'b0;
    idle0("settle_to_check");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "land_lane1");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "ride_hold");
    set_log(3, 10'd600); set_log(4, 10'd190);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd1, "ride_idx1");
    set_log(3, 10'd180);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "lowest_wins");

    // Hop overrides a simultaneous speed pulse
    frog_hop = 1'b1; set_speed(1, 10'd5);
    idle0("hop_over_speed");
    frog_hop = 1'b0; set_speed(1, 10'd0);
    idle0("settle_to_check2");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "reland");

    // Carry in lane 0
    frog_lane = 3'd0; frog_x = 10'd300; set_log(0, 10'd280); set_speed(0, 10'h3FF);
    cyc(1'b1, 1'b1, 10'h3FF, 1'b0, 2'd0, "carry_neg1");
    set_speed(0, 10'd0);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "no_pulse");
    set_log(0, 10'd900); set_log(2, 10'd280);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd2, "lane0_log2");
    set_log(0, 10'd290);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "lane0_lowest");
    frog_in_river = 1'b0;
    idle0("leave_river");

    // Invalid lane while riding
    frog_in_river = 1'b1;
    idle0("idle_to_settle3");
    idle0("settle_to_check3");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "reland_lane0");
    frog_lane = 3'd6;
    cyc(1'b0, 1'b0, 10'd0, 1'b1, 2'd0, "bad_lane_drown");
    idle0("no_repeat");
    respawn = 1'b1; frog_in_river = 1'b0;
    idle0("respawn1");
    respawn = 1'b0;

    // Right bank: 511+1 stays, 512+1 drowns
    frog_lane = 3'd1; frog_x = 10'd511; set_log(3, 10'd500); frog_in_river = 1'b1;
    idle0("idle_to_settle4");
    idle0("settle_to_check4");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "land_edge");
    set_speed(1, 10'd1);
    cyc(1'b1, 1'b1, 10'd1, 1'b0, 2'd0, "edge_ok");
    frog_x = 10'd512;
    cyc(1'b0, 1'b0, 10'd0, 1'b1, 2'd0, "edge_drown");
    set_speed(1, 10'd0);
    idle0("edge_dead_hold");
    respawn = 1'b1; frog_in_river = 1'b0;
    idle0("respawn2");
    respawn = 1'b0;

    // Unsupported landing in lane 3, centre 100
    frog_lane = 3'd3; frog_x = 10'd84; set_log(7, 10'd300); set_log(8, 10'd500);
    frog_in_river = 1'b1; frog_hop = 1'b1;
    idle0("idle_to_settle5");
    frog_hop = 1'b0;
    idle0("settle_to_check5");
`ifdef FROG_GRACE_EN
    for (int i = 0; i < 3; i++) idle0("grace_wait");
    cyc(1'b0, 1'b0, 10'd0, 1'b1, 2'd0, "grace_drown");
    idle0("dead_hold3");
    respawn = 1'b1; frog_in_river = 1'b0;
    idle0("respawn3");
    respawn = 1'b0; frog_in_river = 1'b1;
    idle0("idle_to_settle6");
    idle0("settle_to_check6");
    idle0("grace_try");
    set_log(7, 10'd80);
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "grace_rescue");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "grace_ride");
`else
    cyc(1'b0, 1'b0, 10'd0, 1'b1, 2'd0, "check_drown");
    idle0("dead_hold3");
`endif

    // Reset mid-ride with a pending speed pulse
    respawn = 1'b1; frog_in_river = 1'b0;
    idle0("to_idle");
    respawn = 1'b0; frog_in_river = 1'b1; set_log(7, 10'd80);
    idle0("idle_to_settle7");
    idle0("settle_to_check7");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "land_lane3");
    set_speed(3, 10'd3); reset_n = 1'b0;
    idle0("reset_mid_ride");
    reset_n = 1'b1; set_speed(3, 10'd0);
    idle0("after_reset");
    idle0("settle_to_check8");
    cyc(1'b1, 1'b0, 10'd0, 1'b0, 2'd0, "ride_after_reset");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
